// File: rtl/multicycle_control_if.sv
// Instruction handshake between the fetch logic and the multi-cycle control FSM.
// The fetch side is the master (offers instructions), the FSM is the slave.
interface multicycle_control_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_in;

  modport master (
    output instr_valid,
    output instr_in,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_in,
    output instr_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM. Accepts one instruction at a time, walks a
// fixed per-class state sequence and drives the datapath control pins from
// registers only, so no input reaches an output combinationally.
module multicycle_control #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus,
  input  logic                 ZeroFlag,
  output logic [XLEN-1:0]      instruction,
  output logic [4:0]           reg1_addr,
  output logic [4:0]           reg2_addr,
  output logic [4:0]           write_reg_addr,
  output logic                 ctrl0,
  output logic                 ctrl1,
  output logic                 ctrl2,
  output logic                 ctrl3,
  output logic                 ctrl4,
  output logic [2:0]           ALUOp,
  output logic                 done,
  output logic                 branch_taken,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t          r_state;
  cls_t            r_cls;
  logic [XLEN-1:0] r_instruction;
  logic            r_instr_ready;
  logic [4:0]      r_reg1_addr;
  logic [4:0]      r_reg2_addr;
  logic [4:0]      r_write_reg_addr;
  logic            r_ctrl0;
  logic            r_ctrl1;
  logic            r_ctrl2;
  logic            r_ctrl3;
  logic            r_ctrl4;
  logic [2:0]      r_alu_op;
  logic            r_done;
  logic            r_branch_taken;
  logic            r_illegal;

  cls_t            w_cls;
  logic [2:0]      w_alu_op;
  logic            w_rd_nz;
  logic            w_writes_rd;
  logic            w_to_idle;

  // Classify the offered instruction and pick its ALU operation.
  always_comb begin
    w_cls    = C_ILL;
    w_alu_op = ALU_ADD;
    case (bus.instr_in[6:0])
      7'b0110011: begin
        if (bus.instr_in[31:25] == 7'b0000000) begin
          w_cls = C_R;
          case (bus.instr_in[14:12])
            3'b000:  w_alu_op = ALU_ADD;
            3'b111:  w_alu_op = ALU_AND;
            3'b110:  w_alu_op = ALU_OR;
            3'b100:  w_alu_op = ALU_XOR;
            3'b010:  w_alu_op = ALU_SLT;
            default: w_cls    = C_ILL;
          endcase
        end else if (bus.instr_in[31:25] == 7'b0100000 && bus.instr_in[14:12] == 3'b000) begin
          w_cls    = C_R;
          w_alu_op = ALU_SUB;
        end
      end
      7'b0010011: if (bus.instr_in[14:12] == 3'b000) w_cls = C_ADDI;
      7'b0000011: if (bus.instr_in[14:12] == 3'b010) w_cls = C_LW;
      7'b0100011: if (bus.instr_in[14:12] == 3'b010) w_cls = C_SW;
      7'b1100011: begin
        if (bus.instr_in[14:12] == 3'b000) begin
          w_cls    = C_BEQ;
          w_alu_op = ALU_SUB;
        end
      end
      default: w_cls = C_ILL;
    endcase
  end

  assign w_rd_nz     = (r_instruction[11:7] != 5'd0);
  assign w_writes_rd = (w_cls == C_R) || (w_cls == C_ADDI) || (w_cls == C_LW);

  // Decide whether the current state is the final one of its instruction.
  always_comb begin
    w_to_idle = 1'b0;
    case (r_state)
      S_IDLE, S_EXEC: w_to_idle = 1'b0;
      S_DECODE:       w_to_idle = (r_cls == C_ILL);
      S_MEM:          w_to_idle = (r_cls != C_LW);
      default:        w_to_idle = 1'b1;
    endcase
  end

  // State sequencing with outputs registered for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cls            <= C_ILL;
      r_instruction    <= '0;
      r_instr_ready    <= 1'b1;
      r_reg1_addr      <= 5'd0;
      r_reg2_addr      <= 5'd0;
      r_write_reg_addr <= 5'd0;
      r_ctrl0          <= 1'b0;
      r_ctrl1          <= 1'b0;
      r_ctrl2          <= 1'b0;
      r_ctrl3          <= 1'b0;
      r_ctrl4          <= 1'b0;
      r_alu_op         <= ALU_ADD;
      r_done           <= 1'b0;
      r_branch_taken   <= 1'b0;
      r_illegal        <= 1'b0;
    end else begin
      // Strobes and pulses default low; level outputs hold.
      r_ctrl0        <= 1'b0;
      r_ctrl1        <= 1'b0;
      r_ctrl3        <= 1'b0;
      r_ctrl4        <= 1'b0;
      r_done         <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid && r_instr_ready) begin
            r_instruction <= bus.instr_in;
            r_cls         <= w_cls;
            r_state       <= S_DECODE;
            r_instr_ready <= 1'b0;
            if (w_cls == C_ILL) begin
              r_illegal <= 1'b1;
            end else begin
              r_reg1_addr      <= bus.instr_in[19:15];
              r_reg2_addr      <= bus.instr_in[24:20];
              r_write_reg_addr <= w_writes_rd ? bus.instr_in[11:7] : 5'd0;
              r_alu_op         <= w_alu_op;
              r_ctrl2          <= (w_cls == C_ADDI) || (w_cls == C_LW) || (w_cls == C_SW);
            end
          end
        end
        S_DECODE: begin
          if (r_cls != C_ILL) begin
            r_state <= S_EXEC;
            r_ctrl1 <= 1'b1;
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_LW: begin
              r_state <= S_MEM;
              r_ctrl3 <= 1'b1;
            end
            C_SW: begin
              r_state <= S_MEM;
              r_ctrl4 <= 1'b1;
              r_done  <= 1'b1;
            end
            C_BEQ: begin
              r_state        <= S_BR;
              r_done         <= 1'b1;
              r_branch_taken <= ZeroFlag;
            end
            default: begin
              r_state <= S_WB;
              r_ctrl0 <= w_rd_nz;
              r_done  <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (r_cls == C_LW) begin
            r_state <= S_WB;
            r_ctrl3 <= 1'b1;
            r_ctrl0 <= w_rd_nz;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Leaving the last state: back to IDLE with the address/level outputs cleared.
      if (w_to_idle) begin
        r_state          <= S_IDLE;
        r_instr_ready    <= 1'b1;
        r_reg1_addr      <= 5'd0;
        r_reg2_addr      <= 5'd0;
        r_write_reg_addr <= 5'd0;
        r_ctrl2          <= 1'b0;
        r_alu_op         <= ALU_ADD;
      end
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign instruction     = r_instruction;
  assign reg1_addr       = r_reg1_addr;
  assign reg2_addr       = r_reg2_addr;
  assign write_reg_addr  = r_write_reg_addr;
  assign ctrl0           = r_ctrl0;
  assign ctrl1           = r_ctrl1;
  assign ctrl2           = r_ctrl2;
  assign ctrl3           = r_ctrl3;
  assign ctrl4           = r_ctrl4;
  assign ALUOp           = r_alu_op;
  assign done            = r_done;
  assign branch_taken    = r_branch_taken;
  assign illegal         = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions from the test plan plus
// randomized back-to-back traffic, checked cycle by cycle against a model of
// the per-class timing table.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic        ZeroFlag;
  logic [31:0] instruction;
  logic [4:0]  reg1_addr, reg2_addr, write_reg_addr;
  logic        ctrl0, ctrl1, ctrl2, ctrl3, ctrl4;
  logic [2:0]  ALUOp;
  logic        done, branch_taken, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_control_if #(.XLEN(32)) u_if ();

  multicycle_control #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (u_if),
    .ZeroFlag       (ZeroFlag),
    .instruction    (instruction),
    .reg1_addr      (reg1_addr),
    .reg2_addr      (reg2_addr),
    .write_reg_addr (write_reg_addr),
    .ctrl0          (ctrl0),
    .ctrl1          (ctrl1),
    .ctrl2          (ctrl2),
    .ctrl3          (ctrl3),
    .ctrl4          (ctrl4),
    .ALUOp          (ALUOp),
    .done           (done),
    .branch_taken   (branch_taken),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: [26] ready [25] done [24] illegal [23] branch_taken [22] ctrl0
  // [21] ctrl1 [20] ctrl3 [19] ctrl4 [18] ctrl2 [17:15] ALUOp [14:10] rs1 [9:5] rs2 [4:0] rd
  logic [26:0] obs;
  assign obs = {u_if.instr_ready, done, illegal, branch_taken, ctrl0, ctrl1, ctrl3, ctrl4,
                ctrl2, ALUOp, reg1_addr, reg2_addr, write_reg_addr};

  localparam logic [26:0] IDLE_VEC = {1'b1, 26'd0};

  logic [26:0] cap_vec [0:7];
  logic [31:0] cap_ins [0:7];
  int          cap_len;
  int          cap_wait;

  // Instruction class: 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 illegal.
  function automatic int m_cls(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (op)
      7'h33: begin
        if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd4 || f3 == 3'd2)) return 0;
        if (f7 == 7'h20 && f3 == 3'd0) return 0;
        return 5;
      end
      7'h13: return (f3 == 3'd0) ? 1 : 5;
      7'h03: return (f3 == 3'd2) ? 2 : 5;
      7'h23: return (f3 == 3'd2) ? 3 : 5;
      7'h63: return (f3 == 3'd0) ? 4 : 5;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] m_aop(input logic [31:0] ins);
    int c;
    c = m_cls(ins);
    if (c == 4) return 3'b001;
    if (c != 0) return 3'b000;
    if (ins[31:25] == 7'h20) return 3'b001;
    case (ins[14:12])
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      3'd4:    return 3'b100;
      3'd2:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Cycles from accept to the last cycle (done, or the illegal pulse).
  function automatic int m_len(input logic [31:0] ins);
    int c;
    c = m_cls(ins);
    if (c == 2) return 4;
    if (c == 5) return 1;
    return 3;
  endfunction

  // Expected packed outputs k cycles after the accept edge (k = len+1 is IDLE again).
  function automatic logic [26:0] m_vec(input logic [31:0] ins, input logic zf, input int k);
    int   c, n;
    logic lg, wr;
    c  = m_cls(ins);
    n  = m_len(ins);
    lg = (c != 5);
    wr = (c <= 2);
    if (k == n + 1) return IDLE_VEC;
    return {1'b0,
            lg && k == n,
            !lg && k == 1,
            c == 4 && k == n && zf,
            wr && k == n && ins[11:7] != 5'd0,
            lg && k == 2,
            c == 2 && (k == 3 || k == 4),
            c == 3 && k == 3,
            c == 1 || c == 2 || c == 3,
            m_aop(ins),
            ins[19:15],
            ins[24:20],
            wr ? ins[11:7] : 5'd0};
  endfunction

  function automatic logic [26:0] m_mask(input logic [31:0] ins, input int k);
    if (k == m_len(ins) + 1) return {8'hFF, 4'h0, 15'h7FFF};
    if (m_cls(ins) == 5) return {8'hFF, 19'd0};
    return '1;
  endfunction

  // Offer one instruction as soon as ready is high, then record every cycle
  // until ready returns; busy cycles carry random valid/instruction noise.
  task automatic run(input logic [31:0] ins, input logic zf);
    cap_wait = 0;
    while (u_if.instr_ready !== 1'b1 && cap_wait < 10) begin
      @(negedge clk);
      cap_wait++;
    end
    u_if.instr_valid = 1'b1;
    u_if.instr_in    = ins;
    ZeroFlag         = ~zf;
    cap_len          = m_len(ins);
    for (int k = 1; k <= cap_len + 1; k++) begin
      @(negedge clk);
      cap_vec[k] = obs;
      cap_ins[k] = instruction;
      if (k < cap_len) begin
        u_if.instr_valid = 1'($urandom_range(0, 1));
        u_if.instr_in    = $urandom;
      end else begin
        u_if.instr_valid = 1'b0;
      end
      ZeroFlag = (k == 2) ? zf : ~zf;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs1, rs2;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] ops [0:4];
    int t, idx;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    f7  = 7'($urandom);
    t   = $urandom_range(0, 6);
    case (t)
      0: begin
        idx = $urandom_range(0, 5);
        case (idx)
          0: f3 = 3'd0;
          1: f3 = 3'd0;
          2: f3 = 3'd7;
          3: f3 = 3'd6;
          4: f3 = 3'd4;
          default: f3 = 3'd2;
        endcase
        return {(idx == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
      end
      1: return {f7, rs2, rs1, 3'd0, rd, 7'h13};
      2: return {f7, rs2, rs1, 3'd2, rd, 7'h03};
      3: return {f7, rs2, rs1, 3'd2, rd, 7'h23};
      4: return {f7, rs2, rs1, 3'd0, rd, 7'h63};
      5: return {f7, rs2, rs1, 3'($urandom), rd, ops[$urandom_range(0, 4)]};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    u_if.instr_valid = 1'b0;
    u_if.instr_in = 32'h0;
    ZeroFlag = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_outputs got %h expected %h", obs, IDLE_VEC);
    end
    checks++;
    if (instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_ir got %h expected 00000000", instruction);
    end
    // Valid during reset must not be accepted.
    u_if.instr_valid = 1'b1;
    u_if.instr_in = 32'h00800913;
    @(negedge clk);
    checks++;
    if (instruction !== 32'h0 || u_if.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_with_valid got ir=%h ready=%b expected ir=00000000 ready=1", instruction, u_if.instr_ready);
    end
    reset = 1'b0;
    u_if.instr_valid = 1'b0;
    @(negedge clk);
    $display("TXN reset done");
  endtask

  task automatic test_addi();
    logic [31:0] ins;
    ins = 32'h00800913;
    run(ins, 1'b0);
    $display("TXN addi ins=%08h len=%0d", ins, cap_len);
    checks++;
    if (cap_wait != 0) begin errors++; $display("FAIL addi_ready got wait=%0d expected 0", cap_wait); end
    for (int k = 1; k <= cap_len + 1; k++) begin
      checks++;
      if ((cap_vec[k] & m_mask(ins, k)) !== (m_vec(ins, 1'b0, k) & m_mask(ins, k))) begin
        errors++;
        $display("FAIL addi_cycle%0d got %h expected %h", k, cap_vec[k], m_vec(ins, 1'b0, k));
      end
    end
    checks++;
    if (cap_vec[3][25] !== 1'b1 || cap_vec[3][22] !== 1'b1 || cap_vec[1][4:0] !== 5'd18 || cap_ins[1] !== ins) begin
      errors++;
      $display("FAIL addi_direct got done=%b ctrl0=%b rd=%0d ir=%h expected 1 1 18 %h",
               cap_vec[3][25], cap_vec[3][22], cap_vec[1][4:0], cap_ins[1], ins);
    end
  endtask

  task automatic test_lw_sw();
    logic [31:0] list [0:1];
    int c3, c4, c0;
    list[0] = 32'h00102E03;
    list[1] = 32'h012020A3;
    for (int i = 0; i < 2; i++) begin
      run(list[i], 1'b0);
      $display("TXN lw_sw ins=%08h len=%0d", list[i], cap_len);
      checks++;
      if (cap_wait != 0) begin errors++; $display("FAIL lw_sw_ready got wait=%0d expected 0", cap_wait); end
      c3 = 0; c4 = 0; c0 = 0;
      for (int k = 1; k <= cap_len + 1; k++) begin
        checks++;
        if ((cap_vec[k] & m_mask(list[i], k)) !== (m_vec(list[i], 1'b0, k) & m_mask(list[i], k))) begin
          errors++;
          $display("FAIL lw_sw_cycle%0d got %h expected %h", k, cap_vec[k], m_vec(list[i], 1'b0, k));
        end
        c3 += int'(cap_vec[k][20]);
        c4 += int'(cap_vec[k][19]);
        c0 += int'(cap_vec[k][22]);
      end
      checks++;
      if (i == 0 && (c3 != 2 || c0 != 1 || cap_vec[4][25] !== 1'b1 || cap_vec[1][4:0] !== 5'd28)) begin
        errors++;
        $display("FAIL lw_direct got ctrl3_cycles=%0d ctrl0_cycles=%0d done4=%b rd=%0d expected 2 1 1 28",
                 c3, c0, cap_vec[4][25], cap_vec[1][4:0]);
      end
      if (i == 1 && (c4 != 1 || c0 != 0 || cap_vec[3][19] !== 1'b1 || cap_vec[1][9:5] !== 5'd18)) begin
        errors++;
        $display("FAIL sw_direct got ctrl4_cycles=%0d ctrl0_cycles=%0d ctrl4_at3=%b rs2=%0d expected 1 0 1 18",
                 c4, c0, cap_vec[3][19], cap_vec[1][9:5]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] list [0:2];
    int c0;
    list[0] = 32'h01DE0F33;
    list[1] = 32'h41DE0F33;
    list[2] = 32'h00208033;
    for (int i = 0; i < 3; i++) begin
      run(list[i], 1'b0);
      $display("TXN rtype ins=%08h len=%0d", list[i], cap_len);
      checks++;
      if (cap_wait != 0) begin errors++; $display("FAIL rtype_ready got wait=%0d expected 0", cap_wait); end
      c0 = 0;
      for (int k = 1; k <= cap_len + 1; k++) begin
        checks++;
        if ((cap_vec[k] & m_mask(list[i], k)) !== (m_vec(list[i], 1'b0, k) & m_mask(list[i], k))) begin
          errors++;
          $display("FAIL rtype_cycle%0d got %h expected %h", k, cap_vec[k], m_vec(list[i], 1'b0, k));
        end
        c0 += int'(cap_vec[k][22]);
      end
      checks++;
      if (cap_vec[1][17:15] !== ((i == 1) ? 3'b001 : 3'b000) || cap_vec[1][18] !== 1'b0 ||
          c0 != ((i == 2) ? 0 : 1) || cap_vec[3][25] !== 1'b1) begin
        errors++;
        $display("FAIL rtype_direct%0d got aluop=%b ctrl2=%b ctrl0_cycles=%0d done3=%b", i,
                 cap_vec[1][17:15], cap_vec[1][18], c0, cap_vec[3][25]);
      end
    end
  endtask

  task automatic test_beq();
    logic [31:0] ins;
    logic        zf;
    ins = 32'h00208063;
    for (int i = 0; i < 2; i++) begin
      zf = (i == 0);
      run(ins, zf);
      $display("TXN beq ins=%08h zf=%b len=%0d", ins, zf, cap_len);
      checks++;
      if (cap_wait != 0) begin errors++; $display("FAIL beq_ready got wait=%0d expected 0", cap_wait); end
      for (int k = 1; k <= cap_len + 1; k++) begin
        checks++;
        if ((cap_vec[k] & m_mask(ins, k)) !== (m_vec(ins, zf, k) & m_mask(ins, k))) begin
          errors++;
          $display("FAIL beq_cycle%0d got %h expected %h", k, cap_vec[k], m_vec(ins, zf, k));
        end
      end
      checks++;
      if (cap_vec[3][23] !== zf || cap_vec[3][25] !== 1'b1) begin
        errors++;
        $display("FAIL beq_taken got %b done=%b expected %b 1", cap_vec[3][23], cap_vec[3][25], zf);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    ins = 32'h0000007F;
    run(ins, 1'b0);
    $display("TXN illegal ins=%08h len=%0d", ins, cap_len);
    for (int k = 1; k <= cap_len + 1; k++) begin
      checks++;
      if ((cap_vec[k] & m_mask(ins, k)) !== (m_vec(ins, 1'b0, k) & m_mask(ins, k))) begin
        errors++;
        $display("FAIL illegal_cycle%0d got %h expected %h", k, cap_vec[k], m_vec(ins, 1'b0, k));
      end
    end
    checks++;
    if (cap_vec[1][24] !== 1'b1 || cap_vec[1][25] !== 1'b0 || cap_vec[2][26] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_direct got illegal=%b done=%b ready2=%b expected 1 0 1",
               cap_vec[1][24], cap_vec[1][25], cap_vec[2][26]);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    n = 0;
    while (u_if.instr_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    u_if.instr_valid = 1'b1;
    u_if.instr_in    = 32'h00102E03;
    @(negedge clk);
    u_if.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl3 !== 1'b1 || ctrl0 !== 1'b0) begin
      errors++;
      $display("FAIL midop_mem got ctrl3=%b ctrl0=%b expected 1 0", ctrl3, ctrl0);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_VEC || instruction !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset got %h ir=%h expected %h ir=00000000", obs, instruction, IDLE_VEC);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL midop_after got %h expected %h", obs, IDLE_VEC);
    end
    $display("TXN reset_midop lw=00102e03");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic        zf;
    for (int i = 0; i < 40; i++) begin
      ins = gen_instr();
      zf  = 1'($urandom_range(0, 1));
      run(ins, zf);
      $display("TXN random%0d ins=%08h cls=%0d zf=%b len=%0d", i, ins, m_cls(ins), zf, cap_len);
      checks++;
      if (cap_wait != 0) begin errors++; $display("FAIL b2b_ready%0d got wait=%0d expected 0", i, cap_wait); end
      for (int k = 1; k <= cap_len + 1; k++) begin
        checks++;
        if ((cap_vec[k] & m_mask(ins, k)) !== (m_vec(ins, zf, k) & m_mask(ins, k))) begin
          errors++;
          $display("FAIL b2b%0d_cycle%0d ins=%h got %h expected %h", i, k, ins, cap_vec[k], m_vec(ins, zf, k));
        end
      end
      checks++;
      if (m_cls(ins) != 5 && cap_ins[1] !== ins) begin
        errors++;
        $display("FAIL b2b%0d_ir got %h expected %h", i, cap_ins[1], ins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_sw();
    test_rtype();
    test_beq();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
